// File: rtl/mouse_position_tracker_pkg.sv
// Shared definitions for the PS/2 mouse position tracker.
// Holds default screen size, FSM state encoding and status-byte bit positions.
// No ports; imported by the tracker top and its axis accumulator.
package mouse_position_tracker_pkg;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;
  localparam int POS_W         = 10;

  typedef enum logic [1:0] {
    BYTE0  = 2'd0,
    BYTE1  = 2'd1,
    BYTE2  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Status (first) byte layout of a standard 3-byte PS/2 mouse packet.
  localparam int LEFT_BIT   = 0;
  localparam int RIGHT_BIT  = 1;
  localparam int MIDDLE_BIT = 2;
  localparam int SYNC_BIT   = 3;
  localparam int X_SIGN_BIT = 4;
  localparam int Y_SIGN_BIT = 5;
  localparam int X_OVF_BIT  = 6;
  localparam int Y_OVF_BIT  = 7;

endpackage

// File: rtl/mouse_axis_accumulator.sv
// Purpose: one pointer axis, current position plus 9-bit signed delta, clamped to [0, limit].
// Latency: purely combinational; the caller registers the result.
// Backpressure: none, evaluated every cycle.
// Ports: pos (current position), delta (9-bit two's complement), ovf (force delta to 0),
//        invert (subtract instead of add), limit (largest legal position), new_pos (clamped result).
module mouse_axis_accumulator
  import mouse_position_tracker_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [8:0]       delta,
  input  logic             ovf,
  input  logic             invert,
  input  logic [POS_W-1:0] limit,
  output logic [POS_W-1:0] new_pos
);

  // 11 bits signed is enough: pos never exceeds limit (< 768) and |delta| <= 256.
  logic signed [10:0] pos_s;
  logic signed [10:0] delta_s;
  logic signed [10:0] limit_s;
  logic signed [10:0] sum;

  always_comb begin
    pos_s   = signed'({1'b0, pos});
    limit_s = signed'({1'b0, limit});
    // A hardware overflow means the magnitude is unknown, so the move is discarded.
    delta_s = ovf ? 11'sd0 : signed'({{2{delta[8]}}, delta});
    sum     = invert ? (pos_s - delta_s) : (pos_s + delta_s);
    if (sum < 11'sd0) begin
      new_pos = '0;
    end else if (sum > limit_s) begin
      new_pos = limit;
    end else begin
      new_pos = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Purpose: assemble 3-byte PS/2 mouse packets and track a clamped absolute pointer position.
// Latency: third byte strobed in cycle N -> outputs updated with new_event high in cycle N+2.
// Backpressure: none; bytes arriving outside an expected slot (bad sync, UPDATE cycle) are dropped.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid (byte strobe from PS/2 receiver);
//        MOUSE_X_POS/MOUSE_Y_POS (pixels, Y=0 at top), MOUSE_LEFT/RIGHT/MIDDLE (levels),
//        new_event (one-cycle pulse on every committed packet).
module mouse_position_tracker
  import mouse_position_tracker_pkg::*;
#(
  parameter int H_RES          = H_RES_DEFAULT,
  parameter int V_RES          = V_RES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] MOUSE_X_POS,
  output logic [POS_W-1:0] MOUSE_Y_POS,
  output logic             MOUSE_LEFT,
  output logic             MOUSE_RIGHT,
  output logic             MOUSE_MIDDLE,
  output logic             new_event
);

  localparam int             GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES);

  state_t state;
  state_t state_nxt;

  // Latched packet fields.
  logic [2:0]       btn_lat;    // {middle, right, left}
  logic             x_sign;
  logic             y_sign;
  logic             x_ovf;
  logic             y_ovf;
  logic [7:0]       dx_byte;
  logic [7:0]       dy_byte;

  logic [GAP_W-1:0] gap_cnt;
  logic             timed_out;
  logic             ld_status;
  logic             ld_dx;
  logic             ld_dy;
  logic [POS_W-1:0] x_nxt;
  logic [POS_W-1:0] y_nxt;

  // Next-state and byte-load decode.
  always_comb begin
    state_nxt = state;
    ld_status = 1'b0;
    ld_dx     = 1'b0;
    ld_dy     = 1'b0;
    timed_out = (gap_cnt == GAP_MAX);
    case (state)
      BYTE0: begin
        // Only a byte carrying the always-one sync bit can start a packet.
        if (rx_valid && rx_data[SYNC_BIT]) begin
          ld_status = 1'b1;
          state_nxt = BYTE1;
        end
      end
      BYTE1: begin
        // An expired gap wins over a coincident byte: the packet is already stale.
        if (timed_out) begin
          state_nxt = BYTE0;
        end else if (rx_valid) begin
          ld_dx     = 1'b1;
          state_nxt = BYTE2;
        end
      end
      BYTE2: begin
        if (timed_out) begin
          state_nxt = BYTE0;
        end else if (rx_valid) begin
          ld_dy     = 1'b1;
          state_nxt = UPDATE;
        end
      end
      UPDATE:  state_nxt = BYTE0;
      default: state_nxt = BYTE0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BYTE0;
    end else begin
      state <= state_nxt;
    end
  end

  // Inter-byte gap counter: only runs while waiting inside a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (ld_status || ld_dx || ld_dy || timed_out ||
                 !(state == BYTE1 || state == BYTE2)) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_lat <= '0;
      x_sign  <= 1'b0;
      y_sign  <= 1'b0;
      x_ovf   <= 1'b0;
      y_ovf   <= 1'b0;
      dx_byte <= '0;
      dy_byte <= '0;
    end else begin
      if (ld_status) begin
        btn_lat <= {rx_data[MIDDLE_BIT], rx_data[RIGHT_BIT], rx_data[LEFT_BIT]};
        x_sign  <= rx_data[X_SIGN_BIT];
        y_sign  <= rx_data[Y_SIGN_BIT];
        x_ovf   <= rx_data[X_OVF_BIT];
        y_ovf   <= rx_data[Y_OVF_BIT];
      end
      if (ld_dx) dx_byte <= rx_data;
      if (ld_dy) dy_byte <= rx_data;
    end
  end

  mouse_axis_accumulator u_x_axis (
    .pos     (MOUSE_X_POS),
    .delta   ({x_sign, dx_byte}),
    .ovf     (x_ovf),
    .invert  (1'b0),
    .limit   (POS_W'(H_RES - 1)),
    .new_pos (x_nxt)
  );

  // PS/2 reports up as positive, screen Y grows downward.
  mouse_axis_accumulator u_y_axis (
    .pos     (MOUSE_Y_POS),
    .delta   ({y_sign, dy_byte}),
    .ovf     (y_ovf),
    .invert  (1'b1),
    .limit   (POS_W'(V_RES - 1)),
    .new_pos (y_nxt)
  );

  // Position, buttons and event strobe all move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      MOUSE_X_POS  <= POS_W'(H_RES / 2);
      MOUSE_Y_POS  <= POS_W'(V_RES / 2);
      MOUSE_LEFT   <= 1'b0;
      MOUSE_RIGHT  <= 1'b0;
      MOUSE_MIDDLE <= 1'b0;
      new_event    <= 1'b0;
    end else begin
      new_event <= (state == UPDATE);
      if (state == UPDATE) begin
        MOUSE_X_POS  <= x_nxt;
        MOUSE_Y_POS  <= y_nxt;
        MOUSE_LEFT   <= btn_lat[0];
        MOUSE_RIGHT  <= btn_lat[1];
        MOUSE_MIDDLE <= btn_lat[2];
      end
    end
  end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Purpose: self-checking bench for mouse_position_tracker (vector table, corner sequences, random packets).
// Latency: expects new_event exactly two cycles after the third byte strobe.
// Backpressure: none; the bench drives one-cycle rx_valid strobes.
module tb_mouse_position_tracker;

  localparam int T     = 40;
  localparam int H_MAX = 639;
  localparam int V_MAX = 479;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       mouse_left;
  logic       mouse_right;
  logic       mouse_middle;
  logic       new_event;

  always #5 clk = ~clk;

  mouse_position_tracker #(
    .H_RES          (640),
    .V_RES          (480),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .MOUSE_X_POS  (mouse_x),
    .MOUSE_Y_POS  (mouse_y),
    .MOUSE_LEFT   (mouse_left),
    .MOUSE_RIGHT  (mouse_right),
    .MOUSE_MIDDLE (mouse_middle),
    .new_event    (new_event)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ev_total = 0;

  // Reference model state.
  int         m_x;
  int         m_y;
  logic [2:0] m_btn;

  always @(negedge clk) if (new_event === 1'b1) ev_total++;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         ex;
    int         ey;
    logic [2:0] eb;   // {middle, right, left}
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns one negedge later with rx_valid low.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_state(input string tag, input int ex, input int ey, input int eb);
    check({tag, " X"}, int'(mouse_x), ex);
    check({tag, " Y"}, int'(mouse_y), ey);
    check({tag, " buttons"}, int'({mouse_middle, mouse_right, mouse_left}), eb);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int g0, input int g1, input string tag);
    int lat;
    int pulses;
    send_byte(b0);
    idle(g0);
    send_byte(b1);
    idle(g1);
    send_byte(b2);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      if (new_event === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      @(negedge clk);
    end
    check({tag, " event latency"}, lat, 2);
    check({tag, " event pulses"}, pulses, 1);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx;
    int dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    m_x   = clampi(m_x + dx, H_MAX);
    m_y   = clampi(m_y - dy, V_MAX);
    m_btn = b0[2:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    m_x   = 320;
    m_y   = 240;
    m_btn = 3'b000;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int         ev0;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] junk;

    tbl[0]  = '{8'h08, 8'h0A, 8'h00, 330, 240, 3'b000};
    tbl[1]  = '{8'h09, 8'h00, 8'h05, 330, 235, 3'b001};
    tbl[2]  = '{8'h18, 8'h00, 8'h00,  74, 235, 3'b000};
    tbl[3]  = '{8'h18, 8'h00, 8'h00,   0, 235, 3'b000};
    tbl[4]  = '{8'h0A, 8'h7F, 8'h00, 127, 235, 3'b010};
    tbl[5]  = '{8'h0C, 8'hFF, 8'h00, 382, 235, 3'b100};
    tbl[6]  = '{8'h0C, 8'hFF, 8'h00, 637, 235, 3'b100};
    tbl[7]  = '{8'h08, 8'h05, 8'h00, 639, 235, 3'b000};
    tbl[8]  = '{8'h48, 8'hFF, 8'h03, 639, 232, 3'b000};
    tbl[9]  = '{8'h28, 8'h00, 8'h00, 639, 479, 3'b000};
    tbl[10] = '{8'h08, 8'h00, 8'h7F, 639, 352, 3'b000};
    tbl[11] = '{8'h98, 8'h10, 8'hFF, 399, 352, 3'b000};
    tbl[12] = '{8'h3F, 8'hFF, 8'hFF, 398, 353, 3'b111};
    tbl[13] = '{8'h08, 8'h00, 8'h00, 398, 353, 3'b000};
    tbl[14] = '{8'h08, 8'h00, 8'hF0, 398, 113, 3'b000};
    tbl[15] = '{8'h08, 8'h00, 8'h80, 398,   0, 3'b000};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check_state("reset", 320, 240, 0);
    check("reset new_event", int'(new_event), 0);
    rst = 1'b0;
    idle(2);

    // Vector table.
    for (int i = 0; i < 16; i++) begin
      send_packet(tbl[i].b0, tbl[i].b1, tbl[i].b2, i % 3, (i + 1) % 2, $sformatf("vec%0d", i));
      check_state($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].eb));
    end

    // Reset between bytes 1 and 2 discards the packet and restores the centre.
    ev0 = ev_total;
    send_byte(8'h08);
    send_byte(8'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_state("midreset", 320, 240, 0);
    send_byte(8'h00);
    idle(6);
    check("midreset events", ev_total - ev0, 0);
    check("midreset X hold", int'(mouse_x), 320);

    // Two full-scale left moves from the centre: 64, then clamped at 0.
    send_packet(8'h18, 8'h00, 8'h00, 0, 0, "left1");
    check("left1 X", int'(mouse_x), 64);
    send_packet(8'h18, 8'h00, 8'h00, 0, 0, "left2");
    check("left2 X", int'(mouse_x), 0);

    // Lone byte without sync bit is dropped; only the following packet counts.
    ev0 = ev_total;
    send_byte(8'h00);
    idle(1);
    send_packet(8'h08, 8'h03, 8'h00, 0, 0, "lone");
    idle(2);
    check("lone events", ev_total - ev0, 1);
    check("lone X", int'(mouse_x), 3);

    // Partial packet abandoned by the gap timeout.
    ev0 = ev_total;
    send_byte(8'h08);
    send_byte(8'h05);
    idle(T + 5);
    send_packet(8'h08, 8'h01, 8'h00, 0, 0, "timeout");
    idle(2);
    check("timeout events", ev_total - ev0, 1);
    check_state("timeout", 4, 240, 0);

    // Gaps just under the limit still complete the packet.
    ev0 = ev_total;
    send_packet(8'h08, 8'h02, 8'h00, T - 5, T - 5, "slow");
    idle(2);
    check("slow events", ev_total - ev0, 1);
    check("slow X", int'(mouse_x), 6);

    // Byte landing in the UPDATE cycle is dropped, so the rest of that packet is junk.
    ev0 = ev_total;
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h04);
    send_byte(8'h00);
    idle(8);
    check("update-drop events", ev_total - ev0, 1);
    check("update-drop X", int'(mouse_x), 7);

    // Random packets against the reference model.
    do_reset();
    idle(1);
    for (int i = 0; i < 60; i++) begin
      r0    = 8'($urandom);
      r0[3] = 1'b1;
      r1    = 8'($urandom);
      r2    = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        junk    = 8'($urandom);
        junk[3] = 1'b0;
        send_byte(junk);
        idle(1);
      end
      send_packet(r0, r1, r2, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
      model_apply(r0, r1, r2);
      check_state($sformatf("rnd%0d", i), m_x, m_y, int'(m_btn));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mouse_position_tracker.md
# mouse_position_tracker

Upstream stage of the canvas drawing path. Consumes bytes from the PS/2 serial receiver, assembles standard 3-byte mouse packets, and tracks a clamped absolute pointer position in screen pixels. Emits `MOUSE_X_POS`, `MOUSE_Y_POS`, button levels and a one-cycle `new_event` pulse, which the canvas stroke-writer consumes directly (left button drives its `Mouse_write`).

## Interface

Parameters:
- `H_RES`, 640, horizontal pixel count; X range 0..H_RES-1
- `V_RES`, 480, vertical pixel count; Y range 0..V_RES-1
- `TIMEOUT_CYCLES`, 2_000_000, max inter-byte gap inside a packet before resync (20 ms at 100 MHz)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `rx_data`  in  8  received PS/2 byte
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `MOUSE_X_POS`  out  10  pointer X, pixels
- `MOUSE_Y_POS`  out  10  pointer Y, pixels, 0 = top
- `MOUSE_LEFT`  out  1  left button level
- `MOUSE_RIGHT`  out  1  right button level
- `MOUSE_MIDDLE`  out  1  middle button level
- `new_event`  out  1  one-cycle pulse, position/buttons just updated

## Operation

- FSM states: `BYTE0`, `BYTE1`, `BYTE2`, `UPDATE`.
- `BYTE0`: on `rx_valid`, accept only if `rx_data[3]==1` (sync bit); latch as status, go `BYTE1`. Otherwise drop byte, stay.
- `BYTE1`: on `rx_valid`, latch dx byte, go `BYTE2`.
- `BYTE2`: on `rx_valid`, latch dy byte, go `UPDATE`.
- `UPDATE`: one cycle; commit position and buttons, return to `BYTE0`.
- Status byte: bit0 left, bit1 right, bit2 middle, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- dx = signed 9-bit {status[4], dx_byte}; dy = {status[5], dy_byte}.
- X: 11-bit signed sum = X + sext(dx); clamp to [0, H_RES-1].
- Y: PS/2 dy positive = up; 11-bit signed diff = Y − sext(dy); clamp to [0, V_RES-1].
- Overflow bit set on an axis: that axis delta forced to 0; buttons and other axis still update; `new_event` still pulses.
- `new_event` pulses for every valid packet, including zero-motion/no-button-change packets.
- Timeout: gap counter clears on each accepted byte; counts while in `BYTE1`/`BYTE2`; reaching `TIMEOUT_CYCLES` forces `BYTE0`, discards partial packet, no event.
- `rx_valid` in `UPDATE` cycle: byte dropped (receiver rate makes this unreachable in practice; still defined).

## Timing

- Reset values: `MOUSE_X_POS`=H_RES/2 (320), `MOUSE_Y_POS`=V_RES/2 (240), all buttons 0, `new_event` 0, FSM `BYTE0`, gap counter 0.
- `rst` overrides every other input in the same cycle; reset mid-packet discards it.
- Latency: third-byte `rx_valid` at cycle N → FSM in `UPDATE` at N+1 → outputs registered and `new_event`=1 during N+2 only.
- Position, buttons and `new_event` change on the same edge; consumers sample all on the `new_event` cycle; values hold until next event.
- All outputs registered; no combinational path from `rx_*` to outputs.
- Gap counter width: ceil(log2(TIMEOUT_CYCLES+1)); saturates, never wraps.

## Structure

- Shared package: `H_RES`/`V_RES` defaults, FSM state encoding, status-byte bit indices.
- Natural sub-module: `mouse_axis_accumulator` (pos, 9-bit delta, overflow flag, invert, limit → clamped pos), instantiated once per axis.

## Test plan

- Reset, then packet 0x08,0x0A,0x00 → `new_event` 2 cycles after last byte; X=330, Y=240, buttons 0.
- Packet 0x09,0x00,0x05 → left=1, Y=235 (up), X unchanged.
- From X=320: packet 0x18,0x00,0x00 with dx=−256 repeated twice → X=64 then X=0 (clamped, no wrap); +255 from X=630 → X=639.
- Packet 0x48,0xFF,0x03 (X overflow) → X unchanged, Y−3, `new_event` pulses.
- Lone 0x00 byte then valid packet → first byte dropped, single event for valid packet only.
- 0x08,0x05 then gap of TIMEOUT_CYCLES, then 0x08,0x01,0x00 → no event for partial packet; X+1 after new packet; `rst` asserted between bytes 1 and 2 → position back to 320/240, no event.
